// File: rtl/camera_pkg.sv
// Shared types and constants for the camera framebuffer path.
// Bank indices are {0,1,2}, so any two distinct banks identify the third.
package camera_pkg;

  typedef logic [1:0] bank_t;

  localparam int NUM_BANKS        = 3;
  localparam int CAM_FRAME_PIXELS = 76800;

  function automatic bank_t third_bank(bank_t a, bank_t b);
    return bank_t'(NUM_BANKS) - a - b;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// In-bank pixel address generator for the camera writer.
// It gates writes past the frame size and flags the overflow until the frame completes.
module frame_pixel_counter
  import camera_pkg::*;
#(
  parameter int FRAME_PIXELS = CAM_FRAME_PIXELS,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FRAME_PIXELS);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;
  logic              room;

  // A pixel arriving together with frame_done is still written and belongs to the finished frame.
  always_comb begin
    room       = (addr_q < ADDR_LIMIT);
    wr_en      = pixel_valid & room;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    if (frame_done) begin
      addr_d     = '0;
      overflow_d = 1'b0;
    end else if (pixel_valid) begin
      if (room) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_addr  = addr_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler between the camera writer and the scan-out reader.
// The writer never stalls, and the reader only ever switches to a fully written bank.
module frame_bank_scheduler
  import camera_pkg::*;
#(
  parameter int FRAME_PIXELS = CAM_FRAME_PIXELS,
  parameter int ADDR_W       = 17,
  parameter int DROP_W       = 16
) (
  input  logic              system_clock_in,
  input  logic              reset_in,
  input  logic              wr_pixel_valid,
  input  logic              wr_frame_done,
  output logic              wr_en,
  output bank_t             wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_frame_start,
  output bank_t             rd_bank,
  output logic              rd_frame_valid,
  output logic              frame_overflow,
  output logic [DROP_W-1:0] frames_dropped
);

  bank_t             wr_bank_q, wr_bank_d;
  bank_t             rd_bank_q, rd_bank_d;
  bank_t             latest_bank;
  logic              fresh_q, fresh_d;
  logic              valid_q, valid_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              drop_event;

  frame_pixel_counter #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W)
  ) u_pixel_counter (
    .clk         (system_clock_in),
    .rst         (reset_in),
    .pixel_valid (wr_pixel_valid),
    .frame_done  (wr_frame_done),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .overflow    (frame_overflow)
  );

  // The latest bank is never stored; it is whichever bank neither side owns.
  assign latest_bank = third_bank(wr_bank_q, rd_bank_q);

  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    fresh_d    = fresh_q;
    valid_d    = valid_q;
    drop_event = wr_frame_done & fresh_q;
    if (wr_frame_done && rd_frame_start) begin
      wr_bank_d = rd_bank_q;
      rd_bank_d = wr_bank_q;
      fresh_d   = 1'b0;
      valid_d   = 1'b1;
    end else if (wr_frame_done) begin
      wr_bank_d = latest_bank;
      fresh_d   = 1'b1;
    end else if (rd_frame_start && fresh_q) begin
      rd_bank_d = latest_bank;
      fresh_d   = 1'b0;
      valid_d   = 1'b1;
    end
    dropped_d = dropped_q;
    if (drop_event && (dropped_q != '1)) begin
      dropped_d = dropped_q + DROP_W'(1);
    end
  end

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_bank_q <= bank_t'(0);
      rd_bank_q <= bank_t'(2);
      fresh_q   <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      fresh_q   <= fresh_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign wr_bank        = wr_bank_q;
  assign rd_bank        = rd_bank_q;
  assign rd_frame_valid = valid_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: a role-based triple-buffer model checked every
// cycle, randomized traffic, and literal expectations for the directed corner cases.
module tb_frame_bank_scheduler;

  localparam int FP = 76800;

  logic        clk;
  logic        reset_in;
  logic        pv;
  logic        fd;
  logic        fs;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [16:0] wr_addr;
  logic [1:0]  rd_bank;
  logic        rd_frame_valid;
  logic        frame_overflow;
  logic [15:0] frames_dropped;

  int checks = 0;
  int errors = 0;

  int m_wr = 0, m_rd = 2, m_latest = 1, m_fresh = 0, m_valid = 0;
  int m_addr = 0, m_ovf = 0, m_drop = 0;

  frame_bank_scheduler dut (
    .system_clock_in (clk),
    .reset_in        (reset_in),
    .wr_pixel_valid  (pv),
    .wr_frame_done   (fd),
    .wr_en           (wr_en),
    .wr_bank         (wr_bank),
    .wr_addr         (wr_addr),
    .rd_frame_start  (fs),
    .rd_bank         (rd_bank),
    .rd_frame_valid  (rd_frame_valid),
    .frame_overflow  (frame_overflow),
    .frames_dropped  (frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic d, input logic s);
    @(negedge clk);
    #1;
    pv = p;
    fd = d;
    fs = s;
  endtask

  // Reference model: three banks with roles writer/latest/reader, plus a pixel count per frame.
  always @(posedge clk or posedge reset_in) begin
    int t;
    if (reset_in) begin
      m_wr = 0; m_latest = 1; m_rd = 2;
      m_fresh = 0; m_valid = 0; m_addr = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (pv) begin
        if (m_addr < FP) m_addr = m_addr + 1;
        else m_ovf = 1;
      end
      if (fd) begin
        m_addr = 0;
        m_ovf = 0;
        if (m_fresh == 1 && m_drop < 65535) m_drop = m_drop + 1;
      end
      if (fd && fs) begin
        t = m_wr; m_wr = m_rd; m_rd = t;
        m_fresh = 0; m_valid = 1;
      end else if (fd) begin
        t = m_wr; m_wr = m_latest; m_latest = t;
        m_fresh = 1;
      end else if (fs && m_fresh == 1) begin
        t = m_rd; m_rd = m_latest; m_latest = t;
        m_fresh = 0; m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_in) begin
      checkOutput("wr_en", int'(wr_en), (pv && m_addr < FP) ? 1 : 0);
      checkOutput("wr_bank", int'(wr_bank), m_wr);
      checkOutput("rd_bank", int'(rd_bank), m_rd);
      checkOutput("wr_addr", int'(wr_addr), m_addr);
      checkOutput("rd_frame_valid", int'(rd_frame_valid), m_valid);
      checkOutput("frame_overflow", int'(frame_overflow), m_ovf);
      checkOutput("frames_dropped", int'(frames_dropped), m_drop);
    end
  end

  initial begin
    pv = 1'b0; fd = 1'b0; fs = 1'b0;
    reset_in = 1'b0;
    #1 reset_in = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset_in = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("reset_wr_bank", int'(wr_bank), 0);
    checkOutput("reset_rd_bank", int'(rd_bank), 2);
    checkOutput("reset_wr_addr", int'(wr_addr), 0);
    checkOutput("reset_valid", int'(rd_frame_valid), 0);
    checkOutput("reset_dropped", int'(frames_dropped), 0);

    // Full frame plus five excess pixels.
    for (int i = 0; i < FP + 5; i++) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("full_addr_held", int'(wr_addr), 76800);
    checkOutput("full_overflow", int'(frame_overflow), 1);
    checkOutput("full_wr_bank", int'(wr_bank), 0);
    applyStimulus(1, 0, 0);
    checkOutput("excess_wr_en", int'(wr_en), 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("done_wr_bank", int'(wr_bank), 1);
    checkOutput("done_overflow_clr", int'(frame_overflow), 0);
    checkOutput("done_addr", int'(wr_addr), 0);
    checkOutput("done_rd_unchanged", int'(rd_bank), 2);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("first_rd_bank", int'(rd_bank), 0);
    checkOutput("first_valid", int'(rd_frame_valid), 1);

    // Three completed frames without the reader: two are dropped.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("drop_count", int'(frames_dropped), 2);
    checkOutput("drop_wr_bank", int'(wr_bank), 2);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("third_frame_rd", int'(rd_bank), 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("stale_rd_repeat", int'(rd_bank), 1);
    checkOutput("stale_dropped", int'(frames_dropped), 2);

    // Pixel, frame_done and frame_start in one cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("triple_wr_en", int'(wr_en), 1);
    checkOutput("triple_old_bank", int'(wr_bank), 2);
    checkOutput("triple_addr", int'(wr_addr), 3);
    applyStimulus(0, 0, 0);
    checkOutput("triple_rd_bank", int'(rd_bank), 2);
    checkOutput("triple_wr_bank", int'(wr_bank), 1);
    checkOutput("triple_addr_clr", int'(wr_addr), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 7),
                    logic'($urandom_range(0, 149) == 0),
                    logic'($urandom_range(0, 99) == 0));
    end

    // Reset in the middle of a frame with a fresh frame pending.
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 1000; i++) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("mid_addr", int'(wr_addr), 1000);
    #1 reset_in = 1'b1;
    #1;
    checkOutput("async_wr_addr", int'(wr_addr), 0);
    checkOutput("async_wr_bank", int'(wr_bank), 0);
    checkOutput("async_rd_bank", int'(rd_bank), 2);
    checkOutput("async_valid", int'(rd_frame_valid), 0);
    checkOutput("async_overflow", int'(frame_overflow), 0);
    checkOutput("async_dropped", int'(frames_dropped), 0);
    checkOutput("async_wr_en", int'(wr_en), 0);
    repeat (2) @(negedge clk);
    #1 reset_in = 1'b0;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("post_reset_rd", int'(rd_bank), 2);
    checkOutput("post_reset_valid", int'(rd_frame_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
